// File: rtl/uart_rx_if.sv
// Serial-line and receive-status bundle for uart_rx.
// The slave modport is the receiver side; master is the line driver / status consumer.
interface uart_rx_if #(
    parameter int unsigned Nbit = 8
);
    logic            SerialDataIn;
    logic            clr_rx_flag;
    logic [Nbit-1:0] DataRx;
    logic            endRx_flag;
    logic            frame_err;

    modport master (
        output SerialDataIn,
        output clr_rx_flag,
        input  DataRx,
        input  endRx_flag,
        input  frame_err
    );

    modport slave (
        input  SerialDataIn,
        input  clr_rx_flag,
        output DataRx,
        output endRx_flag,
        output frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: start + Nbit data (LSB first) + stop, mid-bit sampling, sticky flags.
// Define UART_RX_PARITY_EN to add one even-parity bit between data and stop.
module uart_rx #(
    parameter int unsigned Nbit     = 8,
    parameter int unsigned baudrate = 9600,
    parameter int unsigned clk_freq = 50000000
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave bus
);

    localparam int unsigned BIT_TIME  = clk_freq / baudrate - 1;
    localparam int unsigned HALF_TIME = BIT_TIME / 2;
    localparam int unsigned CNT_W     = (BIT_TIME > 0) ? $clog2(BIT_TIME + 1) : 1;
    localparam int unsigned IDX_W     = (Nbit > 1) ? $clog2(Nbit) : 1;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t            state, state_nx;
    logic              sync1, rx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [IDX_W-1:0]  idx, idx_nx;
    logic [Nbit-1:0]   shreg, shreg_nx;
    logic [Nbit-1:0]   data, data_nx;
    logic              flag, flag_nx;
    logic              err, err_nx;
    logic              bit_done_c, half_done_c;
`ifdef UART_RX_PARITY_EN
    logic              par, par_nx;
`endif

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            rx    <= 1'b1;
        end else begin
            sync1 <= bus.SerialDataIn;
            rx    <= sync1;
        end
    end

    assign bit_done_c  = (cnt == CNT_W'(BIT_TIME));
    assign half_done_c = (cnt == CNT_W'(HALF_TIME));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            data  <= '0;
            flag  <= 1'b0;
            err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
            shreg <= shreg_nx;
            data  <= data_nx;
            flag  <= flag_nx;
            err   <= err_nx;
`ifdef UART_RX_PARITY_EN
            par   <= par_nx;
`endif
        end
    end

    // Frame sequencing; a completing frame overrides a simultaneous flag clear.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        shreg_nx = shreg;
        data_nx  = data;
        flag_nx  = flag & bus.clr_rx_flag;
        err_nx   = err & bus.clr_rx_flag;
`ifdef UART_RX_PARITY_EN
        par_nx   = par;
`endif
        case (state)
            IDLE: begin
                if (!rx) begin
                    cnt_nx   = '0;
                    state_nx = START;
                end
            end
            START: begin
                if (half_done_c) begin
                    cnt_nx   = '0;
                    idx_nx   = '0;
                    state_nx = rx ? IDLE : DATA;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_done_c) begin
                    shreg_nx[idx] = rx;
                    cnt_nx        = '0;
                    if (idx == IDX_W'(Nbit - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                    end else begin
                        idx_nx = idx + IDX_W'(1);
                    end
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_done_c) begin
                    par_nx   = rx;
                    cnt_nx   = '0;
                    state_nx = STOP;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                // Sampled mid-bit; returning to IDLE early permits back-to-back frames.
                if (bit_done_c) begin
                    cnt_nx   = '0;
                    data_nx  = shreg;
                    flag_nx  = 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (!rx || (par != ^shreg)) err_nx = 1'b1;
`else
                    if (!rx) err_nx = 1'b1;
`endif
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                cnt_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

    assign bus.DataRx     = data;
    assign bus.endRx_flag = flag;
    assign bus.frame_err  = err;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter Nbit, default 8, number of data bits per frame.
REQ-002 SHALL have parameter baudrate, default 9600, line rate in bit/s.
REQ-003 SHALL have parameter clk_freq, default 50000000, system clock in Hz.
REQ-004 SHALL have port clk, input, 1, single system clock, all logic on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port SerialDataIn, input, 1, asynchronous serial line, idle high.
REQ-007 SHALL have port clr_rx_flag, input, 1, active-low clear of endRx_flag and frame_err.
REQ-008 SHALL have port DataRx, output, Nbit, last received data word, LSB first on line.
REQ-009 SHALL have port endRx_flag, output, 1, sticky frame-received flag.
REQ-010 SHALL have port frame_err, output, 1, sticky error flag (bad stop bit or, if enabled, bad parity).

Function
REQ-011 SHALL define bit_time = clk_freq/baudrate - 1 and half_time = bit_time/2, both integer-truncated; counter width = ceil(log2(bit_time+1)).
REQ-012 SHALL pass SerialDataIn through a 2-flop synchronizer reset to 1; all decisions use the synchronized value (2-cycle input latency).
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-014 IDLE: on synchronized line = 0, clear baud counter, go to START.
REQ-015 START: at count = half_time, resample; 0 -> clear counter, go to DATA; 1 -> glitch, return to IDLE, no flag, no error.
REQ-016 DATA: at each count = bit_time, sample line into shift register bit bit_index (index 0 first), clear counter; after bit Nbit-1 go to PARITY if enabled, else STOP.
REQ-017 STOP: at count = bit_time, sample; update DataRx from shift register, set endRx_flag; set frame_err if stop sample = 0 (or parity mismatch); go to IDLE.
REQ-018 Stop-bit sample SHALL occur mid-bit; return to IDLE SHALL not wait for end of stop bit, allowing back-to-back frames.
REQ-019 DataRx SHALL change only on frame completion, including errored frames; it holds its value otherwise.
REQ-020 clr_rx_flag = 0 SHALL clear endRx_flag and frame_err next edge without disturbing the receive FSM.
REQ-021 If a frame completes in the same cycle clr_rx_flag = 0, set SHALL win (flag = 1).
REQ-022 A new frame completing while endRx_flag = 1 SHALL overwrite DataRx; flag stays 1.
REQ-023 Baud counter SHALL never exceed bit_time; no wrap-around.

Reset
REQ-024 While reset = 1: state IDLE, counters 0, shift register 0, synchronizer flops 1, DataRx = 0, endRx_flag = 0, frame_err = 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame without setting any flag; after release, reception resumes at next falling edge.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: PARITY state present; one even-parity bit after data, sampled at count = bit_time; mismatch sets frame_err at STOP.
REQ-027 Macro UART_RX_PARITY_EN undefined: PARITY state and logic absent; frame is start + Nbit data + stop; frame_err reflects stop bit only.

Verification
REQ-028 Defaults, send 0xA5 with valid stop -> DataRx = 0xA5, endRx_flag = 1, frame_err = 0, about 9.5 bit times after start edge.
REQ-029 Low pulse of 1000 clk on idle line -> returns to IDLE; endRx_flag = 0, DataRx unchanged.
REQ-030 Send 0x3C with stop bit = 0 -> DataRx = 0x3C, endRx_flag = 1, frame_err = 1; clr_rx_flag low one cycle -> both flags 0.
REQ-031 Back-to-back 0x55 then 0xFF, no idle gap -> DataRx = 0xFF, endRx_flag = 1, frame_err = 0.
REQ-032 Assert reset during bit 4 of 0x81, release, send 0x12 -> DataRx = 0x12, endRx_flag = 1.
REQ-033 With UART_RX_PARITY_EN, send 0x07 with parity bit 0 (wrong) -> DataRx = 0x07, frame_err = 1; with parity bit 1 -> frame_err = 0.
